// File: rtl/block_map_pkg.sv
// Shared definitions for the brick field: command encodings, grid geometry,
// block codes and the stage layout generator used by stage_rom.
package block_map_pkg;

  localparam int ROWS   = 30;
  localparam int COLS   = 10;
  localparam int CBITS  = 4;
  localparam int ROW_W  = COLS * CBITS;
  localparam int ADDR_W = 7;

  typedef enum logic [1:0] {
    F_LOAD  = 2'b00,
    F_CLEAR = 2'b01,
    F_SHL   = 2'b10,
    F_SHR   = 2'b11
  } bm_func_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_SHIFT
  } bm_state_e;

  localparam logic [CBITS-1:0] B_EMPTY    = 4'b0000;
  localparam logic [CBITS-1:0] B_HAZARD   = 4'b0001;
  localparam logic [CBITS-1:0] B_SOLID    = 4'b0111;
  localparam logic [CBITS-1:0] B_HARD     = 4'b0110;
  localparam logic [CBITS-1:0] B_HARD_HIT = 4'b0010;

  // Procedural stage layouts: the top 12 rows hold bricks, the rest is empty.
  function automatic logic [ROW_W-1:0] stage_row(input logic [1:0] stage,
                                                 input logic [4:0] row);
    logic [ROW_W-1:0] bits;
    bits = '0;
    for (int c = 0; c < COLS; c++) begin
      if (row < 5'd12 && ((c + int'(row) + int'(stage)) % 3) != 0) begin
        bits[c*CBITS +: CBITS] = CBITS'((int'(stage) + int'(row) + c) % 8);
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/stage_rom.sv
// Stage layout ROM, 4 stages x 32 rows x 40 bits, registered output (1-cycle latency).
module stage_rom
  import block_map_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  output logic [ROW_W-1:0]  data
);

  logic [ROW_W-1:0] data_q;
  logic [ROW_W-1:0] data_d;

  always_comb begin
    data_d = stage_row(addr[6:5], addr[4:0]);
  end

  always_ff @(posedge clock) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/block_map.sv
// Brick-field grid store: load/clear/rotate commands plus a zero-latency cell read.
// Optional BM_HARD_HITS_EN: clearing a two-hit block leaves its one-hit core.
module block_map
  import block_map_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              bm_enable,
  input  logic [1:0]        bm_func,
  input  logic [1:0]        bm_stage,
  input  logic [4:0]        bm_row,
  input  logic [4:0]        bm_col,
  output logic              bm_ready,
  output logic [CBITS-1:0]  bm_block,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROW_W-1:0]  rom_data
);

  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  bm_state_e  state_q, state_d;
  logic [1:0] stage_q, stage_d;
  logic [4:0] row_q, row_d;
  logic       shl_q, shl_d;
  logic       wr_en_q, wr_en_d;
  logic [4:0] wr_row_q, wr_row_d;

  logic [ROW_W-1:0] grid [ROWS];
  logic             in_range;
  logic [CBITS-1:0] cell_rd;
  logic [CBITS-1:0] clr_code;
  logic             clr_en;
  logic             shift_en;

  assign in_range = (bm_row < 5'(ROWS)) && (bm_col < 5'(COLS));

  always_comb begin
    cell_rd = B_EMPTY;
    if (in_range) cell_rd = grid[bm_row][int'(bm_col)*CBITS +: CBITS];
  end

  always_comb begin
`ifdef BM_HARD_HITS_EN
    clr_code = (cell_rd == B_HARD) ? B_HARD_HIT : B_EMPTY;
`else
    clr_code = B_EMPTY;
`endif
  end

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    row_d    = row_q;
    shl_d    = shl_q;
    wr_en_d  = 1'b0;
    wr_row_d = row_q;
    clr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bm_enable) begin
          case (bm_func_e'(bm_func))
            F_LOAD: begin
              state_d = S_LOAD;
              stage_d = bm_stage;
              row_d   = '0;
            end
            F_CLEAR: clr_en = in_range;
            default: begin
              state_d = S_SHIFT;
              shl_d   = (bm_func_e'(bm_func) == F_SHL);
              row_d   = '0;
            end
          endcase
        end
      end
      // ROM data lags the address by a cycle, so writes trail the fetch row.
      S_LOAD: begin
        wr_en_d = 1'b1;
        if (row_q == LAST_ROW) state_d = S_DRAIN;
        else                   row_d   = row_q + 5'd1;
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        row_d   = '0;
      end
      S_SHIFT: begin
        if (row_q == LAST_ROW) begin
          state_d = S_IDLE;
          row_d   = '0;
        end else begin
          row_d = row_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      stage_q  <= '0;
      row_q    <= '0;
      shl_q    <= 1'b0;
      wr_en_q  <= 1'b0;
      wr_row_q <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      row_q    <= row_d;
      shl_q    <= shl_d;
      wr_en_q  <= wr_en_d;
      wr_row_q <= wr_row_d;
    end
  end

  assign shift_en = (state_q == S_SHIFT);

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    logic [ROW_W-1:0] cell_q;
    logic [ROW_W-1:0] cell_d;

    always_comb begin
      cell_d = cell_q;
      if (wr_en_q && wr_row_q == 5'(gi)) cell_d = rom_data;
      // Column 0 sits in the LSBs, so a left rotate is a right shift of the row word.
      if (shift_en && row_q == 5'(gi)) begin
        if (shl_q) cell_d = {cell_q[CBITS-1:0], cell_q[ROW_W-1:CBITS]};
        else       cell_d = {cell_q[ROW_W-CBITS-1:0], cell_q[ROW_W-1:ROW_W-CBITS]};
      end
      if (clr_en && bm_row == 5'(gi)) cell_d[int'(bm_col)*CBITS +: CBITS] = clr_code;
    end

    always_ff @(posedge clock) begin
      if (reset) cell_q <= '0;
      else       cell_q <= cell_d;
    end

    assign grid[gi] = cell_q;
  end

  assign bm_ready = (state_q == S_IDLE);
  assign bm_block = bm_ready ? cell_rd : B_EMPTY;
  assign rom_addr = {stage_q, row_q};

endmodule

// File: tb/tb_block_map.sv
// Self-checking bench for block_map: scoreboard of expected cell reads plus busy/ready checks.
module tb_block_map;
  import block_map_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        bm_enable = 1'b0;
  logic [1:0]  bm_func = 2'b00;
  logic [1:0]  bm_stage = 2'b00;
  logic [4:0]  bm_row = 5'd0;
  logic [4:0]  bm_col = 5'd0;
  logic        bm_ready;
  logic [3:0]  bm_block;
  logic [6:0]  rom_addr;
  logic [39:0] rom_data;

  always #5 clock = ~clock;

  block_map dut (
    .clock    (clock),
    .reset    (reset),
    .bm_enable(bm_enable),
    .bm_func  (bm_func),
    .bm_stage (bm_stage),
    .bm_row   (bm_row),
    .bm_col   (bm_col),
    .bm_ready (bm_ready),
    .bm_block (bm_block),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  function automatic logic [3:0] pat(input int s, input int r, input int c);
    return 4'(((c + 1 + r) & 15) ^ ((s << 2) & 15));
  endfunction

  // Stage ROM model with one cycle of read latency.
  always @(posedge clock) begin
    for (int c = 0; c < 10; c++) begin
      rom_data[c*4 +: 4] <= pat(int'(rom_addr[6:5]), int'(rom_addr[4:0]), c);
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] model [30][10];

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int r, input int c, input logic [3:0] exp);
    sb_t e;
    @(posedge clock);
    #1;
    bm_row = 5'(r);
    bm_col = 5'(c);
    e.tag = $sformatf("cell_%0d_%0d", r, c);
    e.exp = 32'(exp);
    sb_q.push_back(e);
    @(negedge clock);
    e = sb_q.pop_front();
    check_val(e.tag, 32'(bm_block), e.exp);
  endtask

  task automatic scan_all();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 10; c++)
        rd(r, c, model[r][c]);
  endtask

  task automatic model_load(input int s);
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 10; c++)
        model[r][c] = pat(s, r, c);
  endtask

  task automatic model_zero();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 10; c++)
        model[r][c] = 4'd0;
  endtask

  task automatic model_shift(input bit left);
    logic [3:0] tmp [10];
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < 10; c++)
        tmp[c] = left ? model[r][(c + 1) % 10] : model[r][(c + 9) % 10];
      for (int c = 0; c < 10; c++)
        model[r][c] = tmp[c];
    end
  endtask

  // Issues one command and counts the cycles ready stays low. While busy it
  // pokes a stray enable, flips bm_stage, and optionally fires a reset.
  task automatic cmd(input logic [1:0] f, input logic [1:0] s, input int r, input int c,
                     input int abort_at, output int busy);
    @(negedge clock);
    bm_enable = 1'b1;
    bm_func   = f;
    bm_stage  = s;
    bm_row    = 5'(r);
    bm_col    = 5'(c);
    @(negedge clock);
    bm_enable = 1'b0;
    busy = 0;
    while (!bm_ready && busy < 100) begin
      busy++;
      if (abort_at != 0 && busy == abort_at) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        break;
      end
      if (busy == 2 && f == 2'(F_LOAD)) check_val("rom_addr", 32'(rom_addr), 32'({s, 5'd1}));
      if (busy == 3) check_val("busy_read", 32'(bm_block), 32'd0);
      if (busy == 5) begin
        bm_enable = 1'b1;
        bm_func   = 2'(F_LOAD);
      end
      if (busy == 6) bm_enable = 1'b0;
      if (busy == 10) bm_stage = ~s;
      @(negedge clock);
    end
    $display("cmd func=%0d stage=%0d row=%0d col=%0d busy=%0d", f, s, r, c, busy);
  endtask

  initial begin
    int busy;
    logic [3:0] hard_exp;
    model_zero();
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_val("reset_ready", 32'(bm_ready), 32'd1);
    check_val("reset_rom_addr", 32'(rom_addr), 32'd0);
    scan_all();
    rd(30, 0, 4'd0);
    rd(0, 10, 4'd0);
    rd(31, 31, 4'd0);

    cmd(2'(F_LOAD), 2'd2, 0, 0, 0, busy);
    check_val("load2_busy", 32'(busy), 32'd31);
    model_load(2);
    scan_all();

    cmd(2'(F_LOAD), 2'd3, 0, 0, 0, busy);
    check_val("load3_busy", 32'(busy), 32'd31);
    model_load(3);
    rd(5, 3, 4'b0101);
    cmd(2'(F_CLEAR), 2'd0, 5, 3, 0, busy);
    check_val("clear_busy", 32'(busy), 32'd0);
    model[5][3] = 4'd0;
    rd(5, 3, 4'd0);
    cmd(2'(F_CLEAR), 2'd0, 31, 3, 0, busy);
    check_val("clear_oor_busy", 32'(busy), 32'd0);
    scan_all();

`ifdef BM_HARD_HITS_EN
    hard_exp = 4'b0010;
`else
    hard_exp = 4'b0000;
`endif
    rd(0, 9, 4'b0110);
    cmd(2'(F_CLEAR), 2'd0, 0, 9, 0, busy);
    rd(0, 9, hard_exp);
    cmd(2'(F_CLEAR), 2'd0, 0, 9, 0, busy);
    rd(0, 9, 4'd0);

    cmd(2'(F_LOAD), 2'd0, 0, 0, 0, busy);
    check_val("load0_busy", 32'(busy), 32'd31);
    model_load(0);
    cmd(2'(F_SHL), 2'd0, 0, 0, 0, busy);
    check_val("shl_busy", 32'(busy), 32'd30);
    model_shift(1'b1);
    rd(0, 0, 4'd2);
    rd(0, 9, 4'd1);
    scan_all();
    cmd(2'(F_SHR), 2'd0, 0, 0, 0, busy);
    check_val("shr_busy", 32'(busy), 32'd30);
    model_shift(1'b0);
    rd(0, 0, 4'd1);
    rd(0, 9, 4'd10);
    scan_all();

    cmd(2'(F_LOAD), 2'd1, 0, 0, 10, busy);
    check_val("abort_ready", 32'(bm_ready), 32'd1);
    model_zero();
    scan_all();
    cmd(2'(F_LOAD), 2'd1, 0, 0, 0, busy);
    check_val("reload_busy", 32'(busy), 32'd31);
    model_load(1);
    scan_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
